// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain controller: FSM encoding and
// the word-to-byte geometry used by the serializer.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  localparam int BYTE_W = 8;

  // Number of bytes carried by one FIFO word.
  function automatic int bytes_per_word(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Holds one FIFO word and presents it one byte at a time, most-significant
// byte first. The byte index tells the controller when the last byte is up.
module word_serializer
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [DATA_W-1:0] word_in,
  output logic [7:0]        byte_out,
  output logic              last_byte
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  idx;

  // Load a fresh word, or shift the next byte into the top position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      idx       <= '0;
    end else if (load) begin
      shift_reg <= word_in;
      idx       <= '0;
    end else if (advance) begin
      shift_reg <= shift_reg << BYTE_W;
      idx       <= idx + IDX_W'(1);
    end
  end

  assign byte_out  = shift_reg[DATA_W-1 -: 8];
  assign last_byte = (idx == IDX_W'(BPW - 1));

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains a FIFO in bursts onto a byte-wide valid/ready link. A burst starts
// on an occupancy threshold or after an idle timeout and moves at most the
// number of words that were present when it started.
//
// Handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
// while tx_valid is high and tx_ready low, tx_valid and tx_data hold.
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [CNT_W-1:0]  burst_thr,
  input  logic [TMO_W-1:0]  timeout,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_counter,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [15:0]       words_sent,
  output logic [1:0]        state_dbg
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   burst_rem;
  logic [CNT_W-1:0]   rem_dec;
  logic [TMO_W-1:0]   idle_tmr;
  logic               trigger;
  logic               accept;
  logic               last_byte;
  logic               word_done;

  assign trigger = enable && !fifo_empty &&
                   (((burst_thr != '0) && (fifo_counter >= burst_thr)) ||
                    ((timeout != '0) && (idle_tmr >= timeout)));

  assign accept    = tx_valid && tx_ready;
  assign word_done = accept && last_byte;
  assign rem_dec   = burst_rem - CNT_W'(1);

  assign fifo_rd_en = (state == ST_POP);
  assign tx_valid   = (state == ST_SEND);
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: pop, wait one cycle for read data, then serialize.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (trigger) state_nxt = ST_POP;
      ST_POP:  state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: begin
        if (word_done) begin
          if ((rem_dec != '0) && !fifo_empty && enable) state_nxt = ST_POP;
          else                                           state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Burst length is frozen at start so later writes cannot extend it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                burst_rem <= '0;
    else if ((state == ST_IDLE) && trigger) burst_rem <= fifo_counter;
    else if (word_done)                     burst_rem <= rem_dec;
  end

  // Idle timer: counts non-empty idle cycles, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             idle_tmr <= '0;
    else if ((state != ST_IDLE) || fifo_empty || trigger) idle_tmr <= '0;
    else if (idle_tmr != '1)                             idle_tmr <= idle_tmr + TMO_W'(1);
  end

  // Completed-word counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            words_sent <= '0;
    else if (word_done) words_sent <= words_sent + 16'd1;
  end

  word_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (state == ST_LOAD),
    .advance   (accept),
    .word_in   (fifo_data),
    .byte_out  (tx_data),
    .last_byte (last_byte)
  );

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural FIFO and a byte
// scoreboard fed from the link handshake.
module tb_fifo_drain_ctrl;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [5:0]  burst_thr;
  logic [15:0] timeout;
  logic        fifo_empty;
  logic [5:0]  fifo_counter;
  logic        fifo_rd_en;
  logic [31:0] fifo_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] words_sent;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] fq[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];

  int cyc = 0;
  int pop_cyc = 0;
  int first_rd_cyc = -1;
  int rd_cnt = 0;
  int gap_cnt = 0;
  int lat_err = 0;
  int stab_err = 0;
  int overlap_err = 0;
  logic       prev_stall = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  fifo_drain_ctrl #(.DATA_W(32), .CNT_W(6), .TMO_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .burst_thr    (burst_thr),
    .timeout      (timeout),
    .fifo_empty   (fifo_empty),
    .fifo_counter (fifo_counter),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_data    (fifo_data),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .words_sent   (words_sent),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // FIFO model and link monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err = stab_err + 1;
      if (fifo_rd_en && tx_valid) overlap_err = overlap_err + 1;
      if (busy && !tx_valid) gap_cnt = gap_cnt + 1;
      if (tx_valid && !prev_valid && (cyc - pop_cyc) != 2) lat_err = lat_err + 1;
      if (fifo_rd_en) begin
        rd_cnt  = rd_cnt + 1;
        pop_cyc = cyc;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (fq.size() > 0) fifo_data = fq.pop_front();
        fifo_counter = 6'(fq.size());
        fifo_empty   = (fq.size() == 0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_valid = tx_valid;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end
  end

  // driver tasks
  task automatic push_word(input logic [31:0] w);
    @(negedge clk); #1;
    fq.push_back(w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    fifo_counter = 6'(fq.size());
    fifo_empty   = 1'b0;
  endtask

  task automatic clear_fifo();
    @(negedge clk); #1;
    fq.delete();
    fifo_counter = 6'd0;
    fifo_empty   = 1'b1;
  endtask

  task automatic clear_stats();
    @(negedge clk); #1;
    got_q.delete();
    exp_q.delete();
    rd_cnt = 0; gap_cnt = 0; lat_err = 0; stab_err = 0; overlap_err = 0;
    first_rd_cyc = -1;
  endtask

  // Wait for a burst to start (if not already) and then finish.
  task automatic wait_idle(input string name, input bit rand_ready);
    bit seen = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      if (busy) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    tx_ready = 1'b1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: burst did not complete (seen=%0d busy=%0d), required completion", name, seen, busy);
    end
    @(negedge clk); #1;
  endtask

  task automatic check_bytes(input string name, input int n);
    checks++;
    if (got_q.size() != n) begin
      errors++;
      $display("FAIL %s_byte_count: got %0d required %0d", name, got_q.size(), n);
    end
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte[%0d]: got %02h required %02h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h required 00", tx_data); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b required 0", fifo_rd_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (words_sent !== 16'd0) begin errors++; $display("FAIL reset_words_sent: got %0d required 0", words_sent); end
    checks++; if (state_dbg !== 2'(ST_IDLE)) begin errors++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
  endtask

  task automatic test_threshold();
    clear_stats();
    burst_thr = 6'd4; timeout = 16'd0; tx_ready = 1'b1; enable = 1'b1;
    push_word(32'h11223344);
    push_word(32'h55667788);
    push_word(32'h99AABBCC);
    push_word(32'hDDEEFF00);
    wait_idle("thr", 1'b0);
    check_bytes("thr", 16);
    checks++; if (words_sent !== 16'd4) begin errors++; $display("FAIL thr_words_sent: got %0d required 4", words_sent); end
    checks++; if (rd_cnt != 4) begin errors++; $display("FAIL thr_rd_pulses: got %0d required 4", rd_cnt); end
    checks++; if (gap_cnt != 8) begin errors++; $display("FAIL thr_gap_cycles: got %0d required 8", gap_cnt); end
    checks++; if (lat_err != 0) begin errors++; $display("FAIL thr_pop_to_valid: got %0d bad latencies required 0", lat_err); end
  endtask

  task automatic test_timeout();
    int t0;
    clear_stats();
    burst_thr = 6'd8; timeout = 16'd10;
    push_word(32'hA1B2C3D4);
    t0 = cyc;
    push_word(32'h0F1E2D3C);
    push_word(32'hCAFEBABE);
    wait_idle("tmo", 1'b0);
    check_bytes("tmo", 12);
    checks++; if ((first_rd_cyc - t0) != 11) begin errors++; $display("FAIL tmo_start_delay: got %0d required 11", first_rd_cyc - t0); end
    checks++; if (words_sent !== 16'd7) begin errors++; $display("FAIL tmo_words_sent: got %0d required 7", words_sent); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b required 0", busy); end
  endtask

  task automatic test_stall();
    clear_stats();
    burst_thr = 6'd2; timeout = 16'd0; tx_ready = 1'b0;
    push_word(32'h01234567);
    push_word(32'h89ABCDEF);
    wait_idle("stall", 1'b1);
    check_bytes("stall", 8);
    checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_stability: got %0d changes required 0", stab_err); end
    checks++; if (overlap_err != 0) begin errors++; $display("FAIL stall_rd_in_send: got %0d required 0", overlap_err); end
    checks++; if (words_sent !== 16'd9) begin errors++; $display("FAIL stall_words_sent: got %0d required 9", words_sent); end
  endtask

  task automatic test_no_extend();
    bit ok = 1'b0;
    clear_stats();
    burst_thr = 6'd2;
    push_word(32'h10203040);
    push_word(32'h50607080);
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); #1; ok = busy; end
    push_word(32'hEEEEEEEE);
    wait_idle("ext", 1'b0);
    check_bytes("ext", 8);
    checks++; if (words_sent !== 16'd11) begin errors++; $display("FAIL ext_words_sent: got %0d required 11", words_sent); end
    checks++; if (fq.size() != 1) begin errors++; $display("FAIL ext_fifo_left: got %0d required 1", fq.size()); end
    enable = 1'b0;
    clear_fifo();
  endtask

  task automatic test_enable_drop();
    bit hit = 1'b0;
    clear_stats();
    burst_thr = 6'd4; enable = 1'b1;
    push_word(32'hDEADBEEF);
    push_word(32'h00000001);
    push_word(32'h00000002);
    push_word(32'h00000003);
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #1;
      if (tx_valid && got_q.size() == 2) hit = 1'b1;
    end
    enable = 1'b0;
    checks++; if (!hit) begin errors++; $display("FAIL drop_reach_byte2: not reached, required reached"); end
    wait_idle("drop", 1'b0);
    check_bytes("drop", 4);
    checks++; if (words_sent !== 16'd12) begin errors++; $display("FAIL drop_words_sent: got %0d required 12", words_sent); end
    checks++; if (state_dbg !== 2'(ST_IDLE)) begin errors++; $display("FAIL drop_state: got %0d required 0", state_dbg); end
    checks++; if (fq.size() != 3) begin errors++; $display("FAIL drop_fifo_left: got %0d required 3", fq.size()); end
    checks++; if (rd_cnt != 1) begin errors++; $display("FAIL drop_rd_pulses: got %0d required 1", rd_cnt); end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    clear_stats();
    burst_thr = 6'd3; enable = 1'b1;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #1;
      if (tx_valid && got_q.size() == 3) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach_byte3: not reached, required reached"); end
    enable = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tx_valid: got %b required 0", tx_valid); end
    checks++; if (words_sent !== 16'd0) begin errors++; $display("FAIL rstmid_words_sent: got %0d required 0", words_sent); end
    checks++; if (state_dbg !== 2'(ST_IDLE)) begin errors++; $display("FAIL rstmid_state: got %0d required 0", state_dbg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    clear_fifo();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_no_trigger();
    clear_stats();
    burst_thr = 6'd0; timeout = 16'd0; enable = 1'b1;
    for (int i = 0; i < 63; i++) push_word(32'(i));
    repeat (200) @(negedge clk);
    #1;
    checks++; if (rd_cnt != 0) begin errors++; $display("FAIL notrig_rd_pulses: got %0d required 0", rd_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL notrig_busy: got %b required 0", busy); end
    checks++; if (fq.size() != 63) begin errors++; $display("FAIL notrig_fifo_left: got %0d required 63", fq.size()); end
    enable = 1'b0;
    clear_fifo();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; burst_thr = 6'd0; timeout = 16'd0;
    fifo_empty = 1'b1; fifo_counter = 6'd0; fifo_data = 32'h0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_threshold();
    test_timeout();
    test_stall();
    test_no_extend();
    test_enable_drop();
    test_reset_mid();
    test_no_trigger();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
